// File: rtl/fixed_pkg.sv
// Shared widths, FSM encoding and output-range helpers for the fixed-point MAC tail.
package fixed_pkg;

    localparam int unsigned A_DEF          = 8;
    localparam int unsigned B_DEF          = 8;
    localparam int unsigned LEN_W_DEF      = 8;
    localparam int unsigned FRAC_SHIFT_DEF = 4;
    localparam int unsigned OUT_W_DEF      = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCUM  = 2'd1,
        ST_QUANT  = 2'd2,
        ST_OUTPUT = 2'd3
    } state_e;

    // Largest value representable in a w-bit signed word.
    function automatic longint out_max(input int unsigned w);
        return (longint'(1) <<< (w - 1)) - longint'(1);
    endfunction

    // Smallest value representable in a w-bit signed word.
    function automatic longint out_min(input int unsigned w);
        return -(longint'(1) <<< (w - 1));
    endfunction

endpackage

// File: rtl/fixed_requant.sv
// Combinational requantizer: round-half-up right shift followed by saturation.
module fixed_requant
    import fixed_pkg::*;
#(
    parameter int unsigned ACC_W      = 24,
    parameter int unsigned FRAC_SHIFT = FRAC_SHIFT_DEF,
    parameter int unsigned OUT_W      = OUT_W_DEF
) (
    input  logic signed [ACC_W-1:0] acc_i,
    output logic signed [OUT_W-1:0] out_o,
    output logic                    sat_o
);

    // One extra bit so the rounding add can never wrap.
    localparam int unsigned Y_W = ACC_W + 1;
    localparam logic signed [Y_W-1:0] Y_MAX = Y_W'(out_max(OUT_W));
    localparam logic signed [Y_W-1:0] Y_MIN = Y_W'(out_min(OUT_W));

    logic signed [Y_W-1:0] x_ext;
    logic signed [Y_W-1:0] y;

    assign x_ext = Y_W'(acc_i);

    // Rounding shift only exists when there are fractional bits to drop.
    generate
        if (FRAC_SHIFT > 0) begin : g_round
            localparam logic signed [Y_W-1:0] RND = Y_W'(longint'(1) <<< (FRAC_SHIFT - 1));
            assign y = (x_ext + RND) >>> FRAC_SHIFT;
        end else begin : g_pass
            assign y = x_ext;
        end
    endgenerate

    // Clamp to the output range and flag any clamping.
    always_comb begin
        out_o = y[OUT_W-1:0];
        sat_o = 1'b0;
        if (y > Y_MAX) begin
            out_o = OUT_W'(Y_MAX);
            sat_o = 1'b1;
        end else if (y < Y_MIN) begin
            out_o = OUT_W'(Y_MIN);
            sat_o = 1'b1;
        end
    end

endmodule

// File: rtl/fixed_mac_accum.sv
// Burst accumulator for multiplier products with requantized valid/ready result.
module fixed_mac_accum
    import fixed_pkg::*;
#(
    parameter int unsigned A          = A_DEF,
    parameter int unsigned B          = B_DEF,
    parameter int unsigned PROD_W     = A + B,
    parameter int unsigned LEN_W      = LEN_W_DEF,
    parameter int unsigned ACC_W      = PROD_W + LEN_W,
    parameter int unsigned FRAC_SHIFT = FRAC_SHIFT_DEF,
    parameter int unsigned OUT_W      = OUT_W_DEF
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_start,
    input  logic [LEN_W-1:0]         i_len,
    input  logic                     i_prod_valid,
    input  logic signed [PROD_W-1:0] i_prod,
    output logic                     o_prod_ready,
    output logic                     o_out_valid,
    output logic signed [OUT_W-1:0]  o_out_data,
    output logic                     o_out_sat,
    input  logic                     i_out_ready,
    output logic                     o_busy
);

    state_e                  state_q, state_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [LEN_W-1:0]        count_q, count_d;
    logic signed [OUT_W-1:0] out_data_q, out_data_d;
    logic                    out_sat_q, out_sat_d;
    logic signed [OUT_W-1:0] req_out_c;
    logic                    req_sat_c;
    logic                    accept_c;

    fixed_requant #(
        .ACC_W      (ACC_W),
        .FRAC_SHIFT (FRAC_SHIFT),
        .OUT_W      (OUT_W)
    ) u_requant (
        .acc_i (acc_q),
        .out_o (req_out_c),
        .sat_o (req_sat_c)
    );

    // Handshake and status flags decode directly from the state register.
    assign o_prod_ready = (state_q == ST_ACCUM);
    assign o_out_valid  = (state_q == ST_OUTPUT);
    assign o_busy       = (state_q != ST_IDLE);
    assign o_out_data   = out_data_q;
    assign o_out_sat    = out_sat_q;
    assign accept_c     = o_prod_ready && i_prod_valid;

    // Next-state, accumulate/count and result capture.
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        count_d    = count_q;
        out_data_d = out_data_q;
        out_sat_d  = out_sat_q;
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    acc_d   = '0;
                    count_d = i_len;
                    state_d = (i_len != '0) ? ST_ACCUM : ST_QUANT;
                end
            end
            ST_ACCUM: begin
                if (accept_c) begin
                    acc_d   = acc_q + ACC_W'(i_prod);
                    count_d = count_q - LEN_W'(1);
                    if (count_q == LEN_W'(1)) begin
                        state_d = ST_QUANT;
                    end
                end
            end
            ST_QUANT: begin
                out_data_d = req_out_c;
                out_sat_d  = req_sat_c;
                state_d    = ST_OUTPUT;
            end
            ST_OUTPUT: begin
                if (i_out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any in-flight burst.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= ST_IDLE;
            acc_q      <= '0;
            count_q    <= '0;
            out_data_q <= '0;
            out_sat_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            count_q    <= count_d;
            out_data_q <= out_data_d;
            out_sat_q  <= out_sat_d;
        end
    end

endmodule
